hub75_rx: RTL and testbench

Receiving end of the HUB75 panel link. The block oversamples the six colour lines, the shift clock, the latch, the output enable and the row-address lines on the system clock. It rebuilds each latched line of pixels and streams it column by column over a valid/ready interface. It is the capture model and loop-back checker for the HUB75 driver; it can also feed a second panel chain.

---
 rtl/hub75_rx_if.sv | 34 +++
 rtl/hub75_rx.sv | 214 +++++++++++++++++++++
 tb/tb_hub75_rx.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_rx_if.sv
// Pixel stream leaving the HUB75 receiver: one column per beat with valid/ready flow control.
interface hub75_rx_if #(
    parameter int WIDTH = 64
);
    localparam int COLW = $clog2(WIDTH);

    logic            out_VALID;
    logic            in_READY;
    logic [COLW-1:0] out_COL;
    logic [4:0]      out_ROW;
    logic [2:0]      out_RGB0;
    logic [2:0]      out_RGB1;
    logic            out_LAST;

    modport master (
        output out_VALID,
        output out_COL,
        output out_ROW,
        output out_RGB0,
        output out_RGB1,
        output out_LAST,
        input  in_READY
    );

    modport slave (
        input  out_VALID,
        input  out_COL,
        input  out_ROW,
        input  out_RGB0,
        input  out_RGB1,
        input  out_LAST,
        output in_READY
    );
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receiver: oversamples the panel link, rebuilds each latched line and
// streams it column by column; also reports nOE on-time and link errors.
module hub75_rx #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [2:0]      in_RGB0,
    input  logic [2:0]      in_RGB1,
    input  logic            in_SCREEN_CLOCK,
    input  logic            in_LATCH,
    input  logic            in_nOE,
    input  logic [4:0]      in_ABCDE,
    hub75_rx_if.master      pix,
    output logic [CNTW-1:0] out_ON_CYCLES,
    output logic            out_ERR_COUNT,
    output logic            out_ERR_OVF
);

    localparam int COLW = $clog2(WIDTH);
    localparam int KW   = $clog2(WIDTH + 2);
    localparam int SW   = 14;

    localparam logic [COLW-1:0] COL_LAST = COLW'(WIDTH - 1);
    localparam logic [KW-1:0]   K_FULL   = KW'(WIDTH);
    localparam logic [KW-1:0]   K_SAT    = KW'(WIDTH + 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge registers
    // ------------------------------------------------------------------
    logic [SW-1:0] sync1_q;
    logic [SW-1:0] sync2_q;
    logic          sclk_prev_q;
    logic          latch_prev_q;

    logic [2:0] rgb0_s;
    logic [2:0] rgb1_s;
    logic       sclk_s;
    logic       latch_s;
    logic       noe_s;
    logic [4:0] abcde_s;
    logic       sclk_rise;
    logic       latch_rise;

    assign {abcde_s, noe_s, latch_s, sclk_s, rgb1_s, rgb0_s} = sync2_q;

    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign latch_rise = latch_s & ~latch_prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sclk_prev_q  <= 1'b0;
            latch_prev_q <= 1'b0;
        end else begin
            sync1_q      <= {in_ABCDE, in_nOE, in_LATCH, in_SCREEN_CLOCK, in_RGB1, in_RGB0};
            sync2_q      <= sync1_q;
            sclk_prev_q  <= sclk_s;
            latch_prev_q <= latch_s;
        end
    end

    // ------------------------------------------------------------------
    // Shift counter, error flags and nOE monitor
    // ------------------------------------------------------------------
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [KW-1:0]   k_shift;
    logic            shift_wr;
    logic [COLW-1:0] k_idx;

    logic            err_count_q;
    logic            err_count_d;
    logic            err_ovf_q;
    logic            err_ovf_d;
    logic [CNTW-1:0] on_cnt_q;
    logic [CNTW-1:0] on_cnt_d;
    logic [CNTW-1:0] on_out_q;
    logic [CNTW-1:0] on_out_d;

    assign shift_wr = sclk_rise && (k_q < K_FULL);
    assign k_idx    = k_q[COLW-1:0];

    // The shift of this cycle is folded in before the latch judges the count.
    always_comb begin
        k_shift = k_q;
        if (sclk_rise && (k_q != K_SAT)) begin
            k_shift = k_q + 1'b1;
        end
        k_d         = latch_rise ? '0 : k_shift;
        err_count_d = err_count_q | (latch_rise && (k_shift != K_FULL));
    end

    always_comb begin
        on_cnt_d = on_cnt_q;
        on_out_d = on_out_q;
        if (latch_rise) begin
            on_cnt_d = '0;
            on_out_d = on_cnt_q;
        end else if (!noe_s && (on_cnt_q != {CNTW{1'b1}})) begin
            on_cnt_d = on_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic [COLW-1:0] col_q;
    logic [COLW-1:0] col_d;
    logic [4:0]      row_q;
    logic [4:0]      row_d;
    logic            load;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        err_ovf_d = err_ovf_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (latch_rise) begin
                    load    = 1'b1;
                    row_d   = abcde_s;
                    col_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A line that lands while the buffer is busy is dropped.
                if (latch_rise) begin
                    err_ovf_d = 1'b1;
                end
                if (pix.in_READY) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = IDLE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            k_q         <= '0;
            err_count_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            on_cnt_q    <= '0;
            on_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            k_q         <= k_d;
            err_count_q <= err_count_d;
            err_ovf_q   <= err_ovf_d;
            on_cnt_q    <= on_cnt_d;
            on_out_q    <= on_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel storage: capture register and drain buffer
    // ------------------------------------------------------------------
    logic [5:0] shift_q  [WIDTH];
    logic [5:0] rowbuf_q [WIDTH];

    always_ff @(posedge clk) begin
        if (shift_wr) begin
            shift_q[k_idx] <= {rgb1_s, rgb0_s};
        end
        if (load) begin
            for (int i = 0; i < WIDTH; i++) begin
                rowbuf_q[i] <= (shift_wr && (k_idx == COLW'(i))) ? {rgb1_s, rgb0_s} : shift_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic draining;

    assign draining      = (state_q == DRAIN);
    assign pix.out_VALID = draining;
    assign pix.out_COL   = col_q;
    assign pix.out_ROW   = row_q;
    assign pix.out_RGB0  = draining ? rowbuf_q[col_q][2:0] : 3'b000;
    assign pix.out_RGB1  = draining ? rowbuf_q[col_q][5:3] : 3'b000;
    assign pix.out_LAST  = draining && (col_q == COL_LAST);

    assign out_ON_CYCLES = on_out_q;
    assign out_ERR_COUNT = err_count_q;
    assign out_ERR_OVF   = err_ovf_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: drives HUB75 line traffic and compares the pixel stream
// and status outputs against a line-level reference model.
module tb_hub75_rx;
    localparam int WIDTH  = 64;
    localparam int CNTW   = 12;
    localparam int COLW   = $clog2(WIDTH);
    localparam int ON_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rstn;
    logic [2:0]      in_RGB0;
    logic [2:0]      in_RGB1;
    logic            sclk;
    logic            latch;
    logic            noe;
    logic [4:0]      abcde;
    logic [CNTW-1:0] on_cycles;
    logic            err_count;
    logic            err_ovf;

    always #5 clk = ~clk;

    hub75_rx_if #(.WIDTH(WIDTH)) pix ();

    hub75_rx #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .in_RGB0         (in_RGB0),
        .in_RGB1         (in_RGB1),
        .in_SCREEN_CLOCK (sclk),
        .in_LATCH        (latch),
        .in_nOE          (noe),
        .in_ABCDE        (abcde),
        .pix             (pix),
        .out_ON_CYCLES   (on_cycles),
        .out_ERR_COUNT   (err_count),
        .out_ERR_OVF     (err_ovf)
    );

    typedef struct packed {
        logic [COLW-1:0] col;
        logic [4:0]      row;
        logic [2:0]      r0;
        logic [2:0]      r1;
        logic            last;
    } beat_t;

    int checks = 0;
    int passed = 0;

    // reference model state
    beat_t      expq[$];
    logic [5:0] m_shift[$];
    logic [5:0] m_rowbuf [WIDTH];
    int         m_k = 0;
    bit         m_err_count = 0;
    bit         m_err_ovf = 0;
    int         m_cnt = 0;
    int         m_exp_on = 0;
    int         m_nlat = 0;
    bit         m_lprev = 0;

    // stimulus control
    int rdy_mode = 0;
    int noe_mode = 0;
    int noe_low_cnt = 0;
    int nbeats = 0;
    bit rec = 0;
    logic [2:0] obs_r0 [WIDTH];
    logic [2:0] obs_r1 [WIDTH];
    logic       obs_last [WIDTH];
    logic [4:0] obs_row;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_shift(input logic [2:0] r0, input logic [2:0] r1);
        if (m_k < WIDTH) m_shift.push_back({r1, r0});
        if (m_k < WIDTH + 1) m_k++;
    endtask

    task automatic model_latch(input logic [4:0] row);
        if (m_k != WIDTH) m_err_count = 1;
        if (expq.size() != 0) begin
            m_err_ovf = 1;
        end else begin
            for (int i = 0; i < m_shift.size(); i++) m_rowbuf[i] = m_shift[i];
            for (int c = 0; c < WIDTH; c++) begin
                beat_t b;
                b.col  = COLW'(c);
                b.row  = row;
                b.r0   = m_rowbuf[c][2:0];
                b.r1   = m_rowbuf[c][5:3];
                b.last = (c == WIDTH - 1);
                expq.push_back(b);
            end
        end
        m_shift.delete();
        m_k = 0;
    endtask

    // one HUB75 line: npix shift pulses then a latch
    task automatic send_line(input int npix, input logic [4:0] row, input bit nominal,
                             input bit simul, input bit probe);
        abcde = row;
        for (int c = 0; c < npix; c++) begin
            logic [2:0] r0;
            logic [2:0] r1;
            int lo;
            int hi;
            if (nominal) begin
                r0 = c[2:0];
                r1 = ~r0;
                lo = 4;
                hi = 4;
            end else begin
                r0 = 3'($urandom);
                r1 = 3'($urandom);
                lo = $urandom_range(6, 4);
                hi = $urandom_range(5, 2);
            end
            sclk = 1'b0;
            in_RGB0 = r0;
            in_RGB1 = r1;
            repeat (lo) tick();
            sclk = 1'b1;
            model_shift(r0, r1);
            if (!(simul && c == npix - 1)) repeat (hi) tick();
        end
        if (!simul) begin
            sclk = 1'b0;
            repeat (3) tick();
        end
        latch = 1'b1;
        model_latch(row);
        if (probe) begin
            tick();
            tick();
            check("latency_early", 32'(pix.out_VALID), 32'd0);
            tick();
            tick();
            check("latency_on", 32'(pix.out_VALID), 32'd1);
        end else begin
            repeat (3) tick();
        end
        latch = 1'b0;
        sclk = 1'b0;
        repeat (2) tick();
        if (m_nlat >= 2) check("on_cycles", 32'(on_cycles), 32'(m_exp_on));
        check("err_count", 32'(err_count), 32'(m_err_count));
        check("err_ovf", 32'(err_ovf), 32'(m_err_ovf));
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (expq.size() == 0 && !pix.out_VALID) done = 1;
            else tick();
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    // ready driver
    initial begin
        int idx;
        idx = 0;
        pix.in_READY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: pix.in_READY = 1'b1;
                1: pix.in_READY = (idx % 4 == 0) || (idx % 4 == 3);
                2: pix.in_READY = 1'($urandom);
                default: pix.in_READY = 1'b0;
            endcase
            idx++;
        end
    end

    // nOE driver
    initial begin
        noe = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (noe_low_cnt > 0) begin
                noe = 1'b0;
                noe_low_cnt--;
            end else if (noe_mode != 0) begin
                noe = 1'($urandom);
            end else begin
                noe = 1'b1;
            end
        end
    end

    // on-time model: nOE-low clocks between successive latch rises seen at the pins
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_cnt = 0;
                m_lprev = 0;
                m_nlat = 0;
            end else begin
                if (latch && !m_lprev) begin
                    m_exp_on = m_cnt;
                    m_cnt = 0;
                    m_nlat++;
                end else if (!noe && m_cnt < ON_MAX) begin
                    m_cnt++;
                end
                m_lprev = latch;
            end
        end
    end

    // stream compare
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && pix.out_VALID) begin
                if (expq.size() == 0) begin
                    check("unexpected_beat", 32'(pix.out_VALID), 32'd0);
                end else begin
                    beat_t act;
                    act.col  = pix.out_COL;
                    act.row  = pix.out_ROW;
                    act.r0   = pix.out_RGB0;
                    act.r1   = pix.out_RGB1;
                    act.last = pix.out_LAST;
                    check("beat", 32'(act), 32'(expq[0]));
                    if (pix.in_READY) begin
                        if (rec) begin
                            obs_r0[pix.out_COL]   = pix.out_RGB0;
                            obs_r1[pix.out_COL]   = pix.out_RGB1;
                            obs_last[pix.out_COL] = pix.out_LAST;
                            obs_row               = pix.out_ROW;
                        end
                        void'(expq.pop_front());
                        nbeats++;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        int b0;
        rstn = 1'b1;
        in_RGB0 = '0;
        in_RGB1 = '0;
        sclk = 1'b0;
        latch = 1'b0;
        abcde = '0;
        #2 rstn = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(pix.out_VALID), 32'd0);
        check("rst_col", 32'(pix.out_COL), 32'd0);
        check("rst_row", 32'(pix.out_ROW), 32'd0);
        check("rst_rgb0", 32'(pix.out_RGB0), 32'd0);
        check("rst_rgb1", 32'(pix.out_RGB1), 32'd0);
        check("rst_last", 32'(pix.out_LAST), 32'd0);
        check("rst_on", 32'(on_cycles), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        // nominal line, row 17
        b0 = nbeats;
        rec = 1;
        send_line(WIDTH, 5'd17, 1, 0, 1);
        wait_drain(400);
        rec = 0;
        check("nom_beats", 32'(nbeats - b0), 32'd64);
        check("nom_col5_rgb0", 32'(obs_r0[5]), 32'd5);
        check("nom_col5_rgb1", 32'(obs_r1[5]), 32'd2);
        check("nom_col63_rgb0", 32'(obs_r0[63]), 32'd7);
        check("nom_col63_rgb1", 32'(obs_r1[63]), 32'd0);
        check("nom_row", 32'(obs_row), 32'd17);
        check("nom_last63", 32'(obs_last[63]), 32'd1);
        check("nom_last62", 32'(obs_last[62]), 32'd0);

        // backpressure 1,0,0,1 with a 100-clock nOE pulse in the row period
        rdy_mode = 1;
        noe_low_cnt = 100;
        b0 = nbeats;
        send_line(WIDTH, 5'd3, 1, 0, 0);
        check("on_cycles_100", 32'(on_cycles), 32'd100);
        wait_drain(800);
        check("bp_beats", 32'(nbeats - b0), 32'd64);

        // random lines, random ready and nOE
        rdy_mode = 2;
        noe_mode = 1;
        for (int n = 0; n < 6; n++) begin
            send_line(WIDTH, 5'($urandom), 0, 1'($urandom), 0);
            wait_drain(2000);
        end
        noe_mode = 0;

        // short line, then a correct one
        send_line(WIDTH - 1, 5'd9, 0, 0, 0);
        check("short_err_count", 32'(err_count), 32'd1);
        wait_drain(2000);
        send_line(WIDTH, 5'd10, 0, 0, 0);
        wait_drain(2000);

        // reset in the middle of a drain
        rdy_mode = 0;
        b0 = nbeats;
        send_line(WIDTH, 5'd21, 0, 0, 0);
        for (int i = 0; i < 200 && (nbeats - b0) < 10; i++) tick();
        check("mid_beats", 32'(nbeats - b0), 32'd10);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(pix.out_VALID), 32'd0);
        check("mid_rst_col", 32'(pix.out_COL), 32'd0);
        check("mid_rst_row", 32'(pix.out_ROW), 32'd0);
        check("mid_rst_rgb", 32'({pix.out_RGB0, pix.out_RGB1}), 32'd0);
        check("mid_rst_last", 32'(pix.out_LAST), 32'd0);
        check("mid_rst_on", 32'(on_cycles), 32'd0);
        check("mid_rst_errs", 32'({err_count, err_ovf}), 32'd0);
        expq.delete();
        m_shift.delete();
        m_k = 0;
        m_err_count = 0;
        m_err_ovf = 0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (2) tick();
        send_line(WIDTH, 5'd4, 0, 0, 0);
        wait_drain(400);

        // over-long line
        send_line(WIDTH + 2, 5'd30, 0, 0, 0);
        check("long_err_count", 32'(err_count), 32'd1);
        wait_drain(400);

        // overflow: two lines latched while stalled
        rdy_mode = 3;
        b0 = nbeats;
        send_line(WIDTH, 5'd5, 0, 0, 0);
        check("ovf_first_clear", 32'(err_ovf), 32'd0);
        send_line(WIDTH, 5'd6, 0, 0, 0);
        check("ovf_set", 32'(err_ovf), 32'd1);
        rdy_mode = 0;
        wait_drain(400);
        check("ovf_beats", 32'(nbeats - b0), 32'd64);

        // on-time counter saturation
        noe_low_cnt = 5000;
        repeat (5010) tick();
        send_line(WIDTH, 5'd7, 1, 0, 0);
        check("on_cycles_sat", 32'(on_cycles), 32'(ON_MAX));
        wait_drain(400);
        check("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
